bcd_timer_multi: RTL
====================

Name: bcd_timer_multi

Overview:
- Parametrised successor of the fixed 100 s down-counter: N-digit BCD timer with programmable start value, pause/resume, clear, optional auto-reload and a one-cycle done strobe.
- Sits between the board clock and the hex_decoder instances. It drives game/round timing on the DE1-SoC; its BCD digits feed the per-digit decoders directly.
- Prescaler is exact (tick every DIV cycles, DIV = CLK_HZ/TICK_HZ), fixing the DIV+1 period of the previous divider.

Parameters:
- CLK_HZ, 50000000: input clock frequency. Integer.
- TICK_HZ, 1: count rate. CLK_HZ must be a multiple of TICK_HZ, and DIV = CLK_HZ/TICK_HZ must be at least 2.
- DIGITS, 3: number of BCD digits, 1..8.
- START_BCD, 12'h100: reset and default reload value. Width 4*DIGITS; every nibble must be 0..9.
- AUTO_RELOAD, 0: 1 = reload and keep running on expiry; 0 = stop at zero.

Ports:
- CLOCK_50, input, 1: system clock, rising edge.
- resetn, input, 1: asynchronous active-low reset.
- start, input, 1: level, sampled each cycle; a high cycle begins counting.
- pause, input, 1: level; high holds the count and the prescaler.
- clear, input, 1: synchronous return to IDLE with the reload value.
- load, input, 1: capture load_value as the new reload value.
- load_value, input, 4*DIGITS: BCD value to load.
- bcd, output, 4*DIGITS: current count. Digit 0 (ones) is in [3:0].
- running, output, 1: high in RUN.
- expired, output, 1: high in EXPIRED.
- done, output, 1: one-cycle pulse on reaching zero.
- tick, output, 1: one-cycle pulse at each count step.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; bcd=START_BCD; reload=START_BCD; prescaler=0.
  - running, expired, done and tick all 0.
- All outputs are registered. States are IDLE, RUN, PAUSED and EXPIRED.
- Input priority each cycle: clear > load > start > pause.
- clear (any state): next state IDLE, bcd=reload, prescaler=0. A simultaneous load is ignored.
- load:
  - Accepted only in IDLE or EXPIRED, and ignored in RUN/PAUSED.
  - Result: reload=load_value, bcd=load_value, next state IDLE.
  - Any nibble greater than 9 is saturated to 9 before storing.
- IDLE + start:
  - If bcd is nonzero: prescaler=0, next state RUN, or PAUSED if pause is also high.
  - If bcd is zero: next state EXPIRED, and done pulses in the following cycle.
- RUN:
  - The prescaler increments every cycle.
  - When prescaler==DIV-1 it wraps to 0, and tick=1 in the next cycle.
  - bcd decrements by one with a BCD borrow chain: a digit at 0 becomes 9 and borrows from the next digit.
  - Pause sampled in a RUN cycle takes effect in the next cycle; that cycle's prescaler/tick action still happens.
- Expiry (the decrement makes bcd zero):
  - done=1 and tick=1, in the same cycle that bcd becomes 0.
  - AUTO_RELOAD=0: next state EXPIRED; bcd holds 0.
  - AUTO_RELOAD=1: bcd=reload and the state stays RUN. bcd never shows 0 (done still pulses). If reload==0, the state goes to EXPIRED instead.
- PAUSED: prescaler and bcd are frozen. When pause goes low, the next state is RUN and the prescaler resumes from its held value, so no partial tick is lost.
- EXPIRED:
  - bcd=0 and expired=1.
  - start: bcd=reload, prescaler=0, next state RUN.
  - load/clear: handled as above.
  - done does not re-pulse while the timer stays in EXPIRED.
- start held high in RUN/PAUSED has no effect. start is level-sampled, not edge-detected; the upstream debouncer provides a pulse.
- The prescaler width is ceil(log2(DIV)). The previous 26'bx self-init test is not used; resetn alone initialises state.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; DIGITS=3; START_BCD=12'h100):
- Reset, then start for 1 cycle:
  - First tick 10 cycles after RUN entry, with bcd=12'h099.
  - After 100 ticks, bcd=12'h000 with done and tick high for exactly 1 cycle, then expired=1 and running=0.
  - bcd never changes afterwards.
- Borrow chain: load 12'h210, start, 1 tick -> 12'h209. Then load 12'h200 (after clear), start, 1 tick -> 12'h199.
- Pause: start, run 4 cycles, pause for 50 cycles, then release:
  - No tick during the pause.
  - The next tick comes exactly 6 cycles after release.
- Simultaneous events:
  - clear+load+start in RUN -> IDLE, bcd=reload, load ignored.
  - load with 12'h1AF -> bcd=12'h199.
  - start with bcd=0 in IDLE -> EXPIRED plus one done pulse.
- AUTO_RELOAD=1, load 12'h003, start:
  - Sequence 003, 002, 001, 003, … with done pulsing every 30 cycles.
  - expired stays 0 and bcd never equals 0.
- Asynchronous reset mid-RUN (resetn low between clock edges): outputs go immediately to reset values, and the next start counts again from 12'h100.

Source files
------------

// File: rtl/bcd_timer_multi.sv
// N-digit BCD down-counter with exact prescaler, pause/resume, clear, load and optional auto-reload.
// All outputs come straight from registers; digit 0 (ones) is bcd[3:0].
module bcd_timer_multi #(
    parameter int                   CLK_HZ      = 50000000,
    parameter int                   TICK_HZ     = 1,
    parameter int                   DIGITS      = 3,
    parameter logic [4*DIGITS-1:0]  START_BCD   = 12'h100,
    parameter bit                   AUTO_RELOAD = 1'b0
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  expired,
    output logic                  done,
    output logic                  tick
);

    localparam int W   = 4 * DIGITS;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bcd_q, bcd_d, reload_q, reload_d;
    logic [W-1:0]    bcd_dec, load_sat;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick_q, tick_d, done_q, done_d;
    logic            dec_zero, wrap;

    // Per-digit decrement and load saturation. A digit borrows when every lower digit is zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] d, raw;
        logic       brw;
        assign d   = bcd_q[4*i +: 4];
        assign raw = load_value[4*i +: 4];
        if (i == 0) begin : g_lsd
            assign brw = 1'b1;
        end else begin : g_hi
            assign brw = (bcd_q[4*i-1:0] == '0);
        end
        assign bcd_dec[4*i +: 4]  = !brw ? d : (d == 4'd0) ? 4'd9 : d - 4'd1;
        assign load_sat[4*i +: 4] = (raw > 4'd9) ? 4'd9 : raw;
    end

    // A zero count seen in RUN is treated as expiry rather than wrapping to all nines.
    assign dec_zero = (bcd_dec == '0) || (bcd_q == '0);
    assign wrap     = (presc_q == PRESC_MAX);

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            bcd_d   = reload_q;
            presc_d = '0;
        end else if (load && (state_q == IDLE || state_q == EXPIRED)) begin
            state_d  = IDLE;
            reload_d = load_sat;
            bcd_d    = load_sat;
            presc_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (bcd_q != '0) begin
                            presc_d = '0;
                            state_d = pause ? PAUSED : RUN;
                        end else begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (dec_zero) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD && reload_q != '0) begin
                                bcd_d = reload_q;
                            end else begin
                                bcd_d   = '0;
                                state_d = EXPIRED;
                            end
                        end else begin
                            bcd_d = bcd_dec;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (pause && state_d == RUN) state_d = PAUSED;
                end
                PAUSED: begin
                    if (!pause) state_d = RUN;
                end
                EXPIRED: begin
                    bcd_d = '0;
                    // Restarting with a zero reload would only re-expire; stay put so done stays quiet.
                    if (start && reload_q != '0) begin
                        bcd_d   = reload_q;
                        presc_d = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            bcd_q    <= START_BCD;
            reload_q <= START_BCD;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign bcd     = bcd_q;
    assign running = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;
    assign tick    = tick_q;

endmodule
